// File: rtl/fsm1_pulse_driver.sv
// Drives the x input of a 4-state pulse counter to a requested state using the fewest pulses.
// Keeps a shadow copy of the counter state and predicts the counter's y output.
module fsm1_pulse_driver #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned GAP_W      = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [1:0] target_i,
  output logic       x_out_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] mirror_state_o,
  output logic       y_expect_o
);

  typedef enum logic [1:0] {StIdle, StPulse, StGap, StDone} state_e;

  // Value of the gap counter on the final idle cycle before the next pulse.
  localparam logic [GAP_W-1:0] GapLast = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_e           state_q;
  logic [1:0]       remain_q;
  logic [1:0]       mirror_q;
  logic [GAP_W-1:0] gap_q;
  logic             x_q;
  logic             busy_q;
  logic             done_q;
  logic             y_q;

  logic [1:0] delta;
  logic [1:0] mirror_inc;

  // Forward distance from the shadow state to the target, wrapping mod 4.
  assign delta      = target_i - mirror_q;
  assign mirror_inc = mirror_q + 2'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      remain_q <= 2'd0;
      mirror_q <= 2'd0;
      gap_q    <= '0;
      x_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      y_q      <= 1'b0;
    end else begin
      x_q    <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (delta == 2'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q  <= StPulse;
              remain_q <= delta;
              x_q      <= 1'b1;
            end
          end
        end
        StPulse: begin
          // The counter advances on this same edge, so the shadow follows here.
          mirror_q <= mirror_inc;
          y_q      <= (mirror_inc == 2'd3);
          remain_q <= remain_q - 2'd1;
          if (remain_q == 2'd1) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (GAP_CYCLES == 0) begin
            x_q <= 1'b1;
          end else begin
            state_q <= StGap;
            gap_q   <= '0;
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            state_q <= StPulse;
            x_q     <= 1'b1;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x_out_o        = x_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign mirror_state_o = mirror_q;
  assign y_expect_o     = y_q;

endmodule

// File: tb/tb_fsm1_pulse_driver.sv
// Bench for fsm1_pulse_driver: two instances (gap 2 and gap 0) share stimulus and are
// compared each cycle against a schedule-based reference model and a pulse-counting counter model.
module tb_fsm1_pulse_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] target;

  logic [1:0] x_s, busy_s, done_s, y_s;
  logic [1:0] mir_s [2];

  int n_tests = 0;
  int n_fail  = 0;

  int gap_of [2] = '{2, 0};
  int active [2];
  int k      [2];
  int n      [2];
  int m      [2];
  int cnt    [2];
  bit x_prev [2];

  always #5 clk = ~clk;

  fsm1_pulse_driver #(.GAP_CYCLES(2), .GAP_W(4)) u_dut_g2 (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .target_i      (target),
    .x_out_o       (x_s[0]),
    .busy_o        (busy_s[0]),
    .done_o        (done_s[0]),
    .mirror_state_o(mir_s[0]),
    .y_expect_o    (y_s[0])
  );

  fsm1_pulse_driver #(.GAP_CYCLES(0), .GAP_W(4)) u_dut_g0 (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .target_i      (target),
    .x_out_o       (x_s[1]),
    .busy_o        (busy_s[1]),
    .done_o        (done_s[1]),
    .mirror_state_o(mir_s[1]),
    .y_expect_o    (y_s[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pulses fall on cycles 1, 1+(g+1), ... after accept; done one cycle after the last one.
  function automatic bit pulse_at(int kk, int nn, int g);
    return kk >= 1 && ((kk - 1) % (g + 1)) == 0 && ((kk - 1) / (g + 1)) < nn;
  endfunction

  function automatic int done_at(int nn, int g);
    return (nn == 0) ? 1 : nn + (nn - 1) * g + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        active[d] = 0;
        m[d]      = 0;
        cnt[d]    = 0;
      end else begin
        if (x_prev[d]) cnt[d] = (cnt[d] + 1) % 4;
        if (active[d] != 0) begin
          if (pulse_at(k[d], n[d], gap_of[d])) m[d] = (m[d] + 1) % 4;
          if (k[d] == done_at(n[d], gap_of[d])) active[d] = 0;
          else k[d]++;
        end else if (start) begin
          n[d]      = (int'(target) - m[d] + 4) % 4;
          active[d] = 1;
          k[d]      = 1;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      bit ex_x, ex_done;
      ex_x    = (active[d] != 0) && pulse_at(k[d], n[d], gap_of[d]);
      ex_done = (active[d] != 0) && (k[d] == done_at(n[d], gap_of[d]));
      check($sformatf("busy g%0d", gap_of[d]), 32'(busy_s[d]), 32'(active[d] != 0));
      check($sformatf("x_out g%0d", gap_of[d]), 32'(x_s[d]), 32'(ex_x));
      check($sformatf("done g%0d", gap_of[d]), 32'(done_s[d]), 32'(ex_done));
      check($sformatf("mirror g%0d", gap_of[d]), 32'(mir_s[d]), 32'(m[d]));
      check($sformatf("y_expect g%0d", gap_of[d]), 32'(y_s[d]), 32'(m[d] == 3));
      check($sformatf("counter track g%0d", gap_of[d]), 32'(mir_s[d]), 32'(cnt[d]));
      x_prev[d] = x_s[d];
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [1:0] t);
    rst    = r;
    start  = s;
    target = t;
    step();
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((active[0] != 0 || active[1] != 0) && guard < 30) begin
      drive(1'b0, 1'b0, 2'($urandom));
      guard++;
    end
    check("idle within bound", 32'(active[0] != 0 || active[1] != 0), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      active[d] = 0; k[d] = 0; n[d] = 0; m[d] = 0; cnt[d] = 0; x_prev[d] = 1'b0;
    end
    rst = 1'b1; start = 1'b0; target = 2'd0;

    // Reset held two cycles.
    drive(1'b1, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 2'd0);
    check("reset x_out", 32'(x_s), 32'd0);
    check("reset mirror", 32'(mir_s[0]), 32'd0);

    // 0 -> 3: three pulses (gap 2: cycles 1,4,7; gap 0: back-to-back).
    drive(1'b0, 1'b1, 2'd3);
    wait_idle();
    check("to3 mirror", 32'(mir_s[0]), 32'd3);
    check("to3 y", 32'(y_s[0]), 32'd1);

    // Wrap 3 -> 1 via 0.
    drive(1'b0, 1'b1, 2'd1);
    wait_idle();
    check("wrap mirror", 32'(mir_s[0]), 32'd1);

    // To 2, then request 2 again: zero pulses.
    drive(1'b0, 1'b1, 2'd2);
    wait_idle();
    drive(1'b0, 1'b1, 2'd2);
    check("zero-pulse done", 32'(done_s), 32'b11);
    wait_idle();

    // Starts while busy are ignored.
    drive(1'b0, 1'b1, 2'd1);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 2'($urandom));
    wait_idle();
    check("ignored start mirror", 32'(mir_s[0]), 32'd1);

    // Reset during the second pulse of a three-pulse request.
    drive(1'b1, 1'b0, 2'd0);
    drive(1'b0, 1'b1, 2'd3);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 2'd0);
    check("second pulse before reset", 32'(x_s[0]), 32'd1);
    drive(1'b1, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 2'd0);
    check("after reset no done", 32'(done_s), 32'd0);

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0), 2'($urandom));
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
